// File: rtl/systolic_pkg.sv
// systolic_pkg: FSM state type and result-width helper shared by the systolic matmul.
package systolic_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, OUTPUT} state_e;

    function automatic int outwidth(input int bitwidth, input int n);
        return 2 * bitwidth + $clog2(n);
    endfunction
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: output-stationary MAC cell forwarding activations right and weights down.
// SYSTOLIC_SIGNED_EN selects two's-complement operands; default is unsigned.
module systolic_pe #(
    parameter int BITWIDTH = 4,
    parameter int OUTWIDTH = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic [BITWIDTH-1:0] a_in,
    input  logic [BITWIDTH-1:0] b_in,
    output logic [BITWIDTH-1:0] a_out,
    output logic [BITWIDTH-1:0] b_out,
    output logic [OUTWIDTH-1:0] acc
);
    logic [BITWIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OUTWIDTH-1:0] acc_q, acc_d, prod;

`ifdef SYSTOLIC_SIGNED_EN
    assign prod = OUTWIDTH'($signed(a_in)) * OUTWIDTH'($signed(b_in));
`else
    assign prod = OUTWIDTH'(a_in) * OUTWIDTH'(b_in);
`endif

    always_comb begin
        a_d   = clr ? '0 : en ? a_in : a_q;
        b_d   = clr ? '0 : en ? b_in : b_q;
        acc_d = clr ? '0 : en ? acc_q + prod : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;
endmodule

// File: rtl/systolic_matmul.sv
// systolic_matmul: serially loaded NxN C = X*W on an output-stationary PE grid.
// SYSTOLIC_SIGNED_EN selects signed operands/results; default is unsigned.
module systolic_matmul
    import systolic_pkg::*;
#(
    parameter int BITWIDTH = 4,
    parameter int N        = 2,
    parameter int OUTWIDTH = outwidth(BITWIDTH, N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] data_in,
    input  logic                load_weights,
    input  logic                load_inputs,
    input  logic                store_outputs,
    output logic [OUTWIDTH-1:0] results,
    output logic                valid_out,
    output logic                busy,
    output logic                weights_ready
);
    localparam int NN   = N * N;
    localparam int IW   = (NN > 1) ? $clog2(NN) : 1;
    localparam int CNTW = $clog2(NN + 3 * N);

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                wr_q, wr_d, vld_q, vld_d, busy_q, busy_d;
    logic [OUTWIDTH-1:0] res_q, res_d;
    logic [BITWIDTH-1:0] w_q [NN];
    logic [BITWIDTH-1:0] w_d [NN];
    logic [BITWIDTH-1:0] x_q [NN];
    logic [BITWIDTH-1:0] x_d [NN];
    logic [OUTWIDTH-1:0] acc [NN];
    logic [BITWIDTH-1:0] a_edge [N];
    logic [BITWIDTH-1:0] b_edge [N];
    logic [BITWIDTH-1:0] a_h [N][N+1];
    logic [BITWIDTH-1:0] b_v [N+1][N];
    logic [IW-1:0]       idx;
    logic                take_w, take_x, last, clr, en;

    assign idx = cnt_q[IW-1:0];
    assign en  = state_q == COMPUTE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        w_d     = w_q;
        x_d     = x_q;
        res_d   = res_q;
        vld_d   = 1'b0;
        clr     = 1'b0;
        last    = cnt_q == CNTW'(NN - 1);
        take_w  = load_weights && (state_q == IDLE || state_q == LOAD_W);
        take_x  = load_inputs && ((state_q == IDLE && wr_q && !load_weights) || state_q == LOAD_X);
        if (take_w) begin
            w_d[idx] = data_in;
            wr_d     = last;
            state_d  = last ? IDLE : LOAD_W;
            cnt_d    = last ? '0 : cnt_q + 1'b1;
        end else if (take_x) begin
            x_d[idx] = data_in;
            clr      = last;
            state_d  = last ? COMPUTE : LOAD_X;
            cnt_d    = last ? '0 : cnt_q + 1'b1;
        end else if (state_q == COMPUTE) begin
            state_d = (cnt_q == CNTW'(3 * N - 3)) ? OUTPUT : COMPUTE;
            cnt_d   = (cnt_q == CNTW'(3 * N - 3)) ? '0 : cnt_q + 1'b1;
        end else if (state_q == OUTPUT && store_outputs) begin
            res_d   = acc[idx];
            vld_d   = 1'b1;
            state_d = last ? IDLE : OUTPUT;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
        end
        busy_d = state_d inside {LOAD_X, COMPUTE, OUTPUT};
    end

    // Row r of X enters at compute cycle k+r, column r of W at k+r, so operands meet diagonally.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_edge[r] = '0;
            b_edge[r] = '0;
            for (int k = 0; k < N; k++) begin
                if (en && cnt_q == CNTW'(k + r)) begin
                    a_edge[r] = x_q[r * N + k];
                    b_edge[r] = w_q[k * N + r];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            w_q     <= '{default: '0};
            x_q     <= '{default: '0};
            res_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            w_q     <= w_d;
            x_q     <= x_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        assign a_h[i][0] = a_edge[i];
        assign b_v[0][i] = b_edge[i];
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(.BITWIDTH(BITWIDTH), .OUTWIDTH(OUTWIDTH)) u_pe (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .clr   (clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc[i*N+j])
            );
        end
    end

    assign results       = res_q;
    assign valid_out     = vld_q;
    assign busy          = busy_q;
    assign weights_ready = wr_q;
endmodule

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter BITWIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter N, default 2, array dimension (NxN PEs, NxN matrices).
REQ-003 SHALL have derived parameter OUTWIDTH, default 2*BITWIDTH+$clog2(N), result width.
REQ-004 SHALL have clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have data_in  input  BITWIDTH  serial operand (weight or activation).
REQ-007 SHALL have load_weights  input  1  accept data_in as the next weight this cycle.
REQ-008 SHALL have load_inputs  input  1  accept data_in as the next activation this cycle.
REQ-009 SHALL have store_outputs  input  1  request the next result this cycle.
REQ-010 SHALL have results  output  OUTWIDTH  registered result element.
REQ-011 SHALL have valid_out  output  1  results valid this cycle.
REQ-012 SHALL have busy  output  1  high in LOAD_X, COMPUTE and OUTPUT.
REQ-013 SHALL have weights_ready  output  1  complete weight matrix held.

Function
REQ-014 SHALL compute C = X*W: X = activations, W = weights, all NxN, all loaded and emitted row-major.
REQ-015 SHALL implement FSM states IDLE, LOAD_W, LOAD_X, COMPUTE, OUTPUT.
REQ-016 IDLE + load_weights: SHALL accept element 0, clear weights_ready, enter LOAD_W.
REQ-017 LOAD_W: SHALL accept one weight per cycle with load_weights high and stall when low; after the N*N-th weight, SHALL set weights_ready and return to IDLE.
REQ-018 IDLE + load_inputs + weights_ready: SHALL accept activation 0 and enter LOAD_X; without weights_ready, load_inputs SHALL be ignored.
REQ-019 LOAD_X: SHALL accept one activation per cycle with load_inputs high and stall when low; after the N*N-th activation, SHALL enter COMPUTE.
REQ-020 COMPUTE: SHALL feed skewed rows/columns into output-stationary PEs for exactly 3N-2 cycles, then enter OUTPUT.
REQ-021 OUTPUT: each cycle k with store_outputs high, SHALL present the next C element on results with valid_out high in cycle k+1; store_outputs low SHALL pause the stream (valid_out low).
REQ-022 After the N*N-th result is emitted, SHALL return to IDLE with weights_ready kept; the weights SHALL be reused by later jobs.
REQ-023 load_weights and load_inputs both high: load_weights SHALL have priority; load_inputs SHALL be ignored.
REQ-024 load_weights, load_inputs and store_outputs SHALL be ignored in states where they are not consumed (no side effects).
REQ-025 Accumulators SHALL be OUTWIDTH wide, never overflow for any operands, and SHALL clear at COMPUTE entry.
REQ-026 valid_out SHALL be low whenever a result is not presented; results SHALL hold their last value when valid_out is low.

Reset
REQ-027 reset SHALL force IDLE, clear all counters, PE registers and accumulators, and clear weights_ready; results=0, valid_out=0, busy=0.
REQ-028 reset mid-operation (any state) SHALL abort the job; no further valid_out SHALL appear until a full new load.

Configuration
REQ-029 With SYSTOLIC_SIGNED_EN defined, operands SHALL be two's complement, sign-extended, and results signed.
REQ-030 Without SYSTOLIC_SIGNED_EN, operands and results SHALL be unsigned and zero-extended.

Structure
REQ-031 Package systolic_pkg SHALL hold the FSM state enum typedef and the OUTWIDTH width function.
REQ-032 The PE (multiply-accumulate, operand forwarding right and down) SHALL be sub-module systolic_pe, instantiated NxN by generate.

Verification (N=2, BITWIDTH=4)
REQ-033 W=1,2,3,4, X=5,6,7,8, store_outputs held high -> results 23,34,31,46 on four consecutive valid_out cycles; first valid_out 3N=6 cycles after the last activation is accepted.
REQ-034 Second job X=1,0,0,1 without reloading weights -> 1,2,3,4.
REQ-035 load_inputs before weights_ready, and with load_weights high in the same cycle -> activations ignored; weights load correctly.
REQ-036 store_outputs toggled 1,0,0,1,1,1 during OUTPUT -> valid_out pattern 0,1,0,0,1,1,1 with values in order.
REQ-037 reset asserted mid-COMPUTE -> no valid_out; weights_ready=0 and results=0 next cycle.
REQ-038 SYSTOLIC_SIGNED_EN, W=all -8 (0x8), X=all -8 -> all results 128; unsigned build, W=X=all 15 -> all results 450.
